// File: rtl/sort_vec_serializer.sv
// sort_vec_serializer
//
// Output-side companion to the sorter's compare-and-exchange network.
// The block captures one full N-word sorted vector and its sort direction over
// a valid/ready handshake. It stores the vector, then streams the words out one
// per handshake, starting with lane 0.
//
// Optional order check, enabled by defining SORT_VEC_SERIALIZER_ORDER_CHECK_EN:
//   - Each transferred word after lane 0 is compared (unsigned) against the
//     word transferred just before it.
//   - A word that breaks the declared direction sets the sticky order_err flag.
//   - order_err is cleared by the next vector capture.
// When the macro is not defined, order_err is tied to 0 and no checker
// hardware is built.
//
// Parameters:
//   DATA_WIDTH  width of one word
//   N           words per vector (1..256)
//   IDX_W       derived width of the word index, max(1, clog2(N))
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_data    packed vector; lane i = in_data[i*DATA_WIDTH +: DATA_WIDTH]
//   in_dir     1 = ascending, 0 = descending
//   in_valid   vector offered
//   in_ready   block can capture a vector (IDLE)
//   out_data   current word
//   out_valid  out_data valid (SEND)
//   out_ready  consumer accepts the word
//   out_idx    lane index of the current word
//   out_last   current word is lane N-1
//   busy       a vector is held
//   order_err  sticky order-violation flag
//
// Every output is decoded from registered state only. No output has a
// combinational path from in_valid or out_ready.

module sort_vec_serializer #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N          = 8,
  localparam int unsigned IDX_W     = (N > 1) ? $clog2(N) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N*DATA_WIDTH-1:0] in_data,
  input  logic                    in_dir,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [DATA_WIDTH-1:0]   out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    busy,
  output logic                    order_err
);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  state_t                state_q;
  state_t                state_d;
  logic [DATA_WIDTH-1:0] lane_q [N];
  logic [IDX_W-1:0]      idx_q;
  logic                  at_last;
  logic                  capture;
  logic                  transfer;
  logic [DATA_WIDTH-1:0] cur_word;

  assign at_last  = (idx_q == LAST_IDX);
  assign capture  = (state_q == IDLE) && in_valid;
  assign transfer = (state_q == SEND) && out_ready;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid) state_d = SEND;
      SEND:    if (out_ready && at_last) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    out_data  = '0;
    out_idx   = '0;
    out_last  = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
      end
      SEND: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out_data  = cur_word;
        out_idx   = idx_q;
        out_last  = at_last;
      end
      default: begin
        in_ready = 1'b0;
      end
    endcase
  end

  // Lane select. The compare-based mux never indexes past N-1, even when N is
  // not a power of two.
  always_comb begin
    cur_word = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (idx_q == IDX_W'(i)) cur_word = lane_q[i];
    end
  end

  // Vector store and word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q <= '0;
      for (int unsigned i = 0; i < N; i++) lane_q[i] <= '0;
    end else if (capture) begin
      idx_q <= '0;
      for (int unsigned i = 0; i < N; i++) begin
        lane_q[i] <= in_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end else if (transfer) begin
      idx_q <= at_last ? '0 : idx_q + IDX_W'(1);
    end
  end

`ifdef SORT_VEC_SERIALIZER_ORDER_CHECK_EN
  logic                  dir_q;
  logic [DATA_WIDTH-1:0] prev_q;
  logic                  err_q;
  logic                  violation;

  // Lane 0 has no predecessor. Equal neighbours are always legal.
  assign violation = (idx_q != '0) &&
                     (dir_q ? (cur_word < prev_q) : (cur_word > prev_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_q  <= 1'b0;
      prev_q <= '0;
      err_q  <= 1'b0;
    end else if (capture) begin
      dir_q <= in_dir;
      err_q <= 1'b0;
    end else if (transfer) begin
      prev_q <= cur_word;
      if (violation) err_q <= 1'b1;
    end
  end

  assign order_err = err_q;
`else
  // The direction only feeds the checker; without the checker it is dropped.
  logic unused_dir;
  assign unused_dir = in_dir;
  assign order_err  = 1'b0;
`endif

endmodule

// File: tb/tb_sort_vec_serializer.sv
module tb_sort_vec_serializer;

  localparam int unsigned DW = 8;
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

`ifdef SORT_VEC_SERIALIZER_ORDER_CHECK_EN
  localparam bit CHK_EN = 1'b1;
`else
  localparam bit CHK_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N*DW-1:0] in_data = '0;
  logic            in_dir = 1'b0;
  logic            in_valid = 1'b0;
  logic            in_ready;
  logic [DW-1:0]   out_data;
  logic            out_valid;
  logic            out_ready = 1'b0;
  logic [IW-1:0]   out_idx;
  logic            out_last;
  logic            busy;
  logic            order_err;

  logic [DW-1:0]   one_in_data = '0;
  logic            one_in_dir = 1'b1;
  logic            one_in_valid = 1'b0;
  logic            one_in_ready;
  logic [DW-1:0]   one_out_data;
  logic            one_out_valid;
  logic            one_out_ready = 1'b0;
  logic [0:0]      one_out_idx;
  logic            one_out_last;
  logic            one_busy;
  logic            one_order_err;

  sort_vec_serializer #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_dir(in_dir),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .busy(busy), .order_err(order_err)
  );

  sort_vec_serializer #(.DATA_WIDTH(DW), .N(1)) dut_one (
    .clk(clk), .rst_n(rst_n), .in_data(one_in_data), .in_dir(one_in_dir),
    .in_valid(one_in_valid), .in_ready(one_in_ready), .out_data(one_out_data),
    .out_valid(one_out_valid), .out_ready(one_out_ready), .out_idx(one_out_idx),
    .out_last(one_out_last), .busy(one_busy), .order_err(one_order_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: the words still owed to the consumer, in order.
  typedef struct {
    logic [DW-1:0] data;
    int unsigned   idx;
    logic          dir;
  } word_t;

  word_t         q[$];
  logic          m_err = 1'b0;
  logic [DW-1:0] m_prev = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_err();
    return CHK_EN && m_err;
  endfunction

  task automatic check_outputs(input string ctx);
    logic busy_e;
    busy_e = (q.size() != 0);
    check({ctx, ".in_ready"},  64'(in_ready),  64'(!busy_e));
    check({ctx, ".out_valid"}, 64'(out_valid), 64'(busy_e));
    check({ctx, ".busy"},      64'(busy),      64'(busy_e));
    check({ctx, ".order_err"}, 64'(order_err), 64'(exp_err()));
    if (busy_e) begin
      check({ctx, ".out_data"}, 64'(out_data), 64'(q[0].data));
      check({ctx, ".out_idx"},  64'(out_idx),  64'(q[0].idx));
      check({ctx, ".out_last"}, 64'(out_last), 64'(q[0].idx == N - 1));
    end
  endtask

  // Called just after a falling edge. It checks the outputs, drives one
  // cycle of inputs, predicts the effect of the next rising edge, and then
  // advances to the next falling edge.
  task automatic step(input string ctx, input logic iv, input logic [N*DW-1:0] d,
                      input logic dr, input logic ordy);
    check_outputs(ctx);
    in_valid  = iv;
    in_data   = d;
    in_dir    = dr;
    out_ready = ordy;
    if (q.size() == 0) begin
      if (iv) begin
        for (int unsigned i = 0; i < N; i++) q.push_back('{data: d[i*DW +: DW], idx: i, dir: dr});
        m_err = 1'b0;
      end
    end else if (ordy) begin
      word_t w;
      w = q.pop_front();
      if (w.idx > 0 && ((w.dir && w.data < m_prev) || (!w.dir && w.data > m_prev))) m_err = 1'b1;
      m_prev = w.data;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  function automatic logic [N*DW-1:0] make_vec(input logic dr, input bit sorted);
    logic [DW-1:0]   lanes [N];
    logic [DW-1:0]   tmp;
    logic [N*DW-1:0] v;
    for (int unsigned i = 0; i < N; i++) lanes[i] = DW'($urandom_range(0, 31));
    if (sorted) begin
      for (int unsigned i = 0; i < N; i++) begin
        for (int unsigned j = 0; j + 1 < N - i; j++) begin
          if (dr ? (lanes[j] > lanes[j+1]) : (lanes[j] < lanes[j+1])) begin
            tmp = lanes[j]; lanes[j] = lanes[j+1]; lanes[j+1] = tmp;
          end
        end
      end
    end
    v = '0;
    for (int unsigned i = 0; i < N; i++) v[i*DW +: DW] = lanes[i];
    return v;
  endfunction

  logic [N*DW-1:0] v_basic;
  logic [N*DW-1:0] v_order;
  logic [N*DW-1:0] v_after;

  initial begin
    v_basic = {8'h0F, 8'h09, 8'h05, 8'h01};
    v_order = {8'h20, 8'h08, 8'h08, 8'h10};
    v_after = {8'hDD, 8'hCC, 8'hBB, 8'hAA};

    // Reset state for both instances
    #1;
    check("rst.in_ready",  64'(in_ready),  64'(1));
    check("rst.out_valid", 64'(out_valid), 64'(0));
    check("rst.busy",      64'(busy),      64'(0));
    check("rst.out_data",  64'(out_data),  64'(0));
    check("rst.out_idx",   64'(out_idx),   64'(0));
    check("rst.out_last",  64'(out_last),  64'(0));
    check("rst.order_err", 64'(order_err), 64'(0));
    check("rst1.in_ready", 64'(one_in_ready), 64'(1));
    check("rst1.out_valid", 64'(one_out_valid), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;

    // Basic stream
    step("basic", 1'b1, v_basic, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 5; i++) step("basic", 1'b0, '0, 1'b0, 1'b1);

    // Backpressure on word 1
    step("bp", 1'b1, v_basic, 1'b1, 1'b1);
    step("bp", 1'b0, '0, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 3; i++) step("bp", 1'b0, '0, 1'b0, 1'b0);
    for (int unsigned i = 0; i < 4; i++) step("bp", 1'b0, '0, 1'b0, 1'b1);

    // Descending vector with an equal pair, then a violating last word
    step("order", 1'b1, v_order, 1'b0, 1'b1);
    for (int unsigned i = 0; i < 5; i++) step("order", 1'b0, '0, 1'b0, 1'b1);
    step("order_clr", 1'b1, v_basic, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 5; i++) step("order_clr", 1'b0, '0, 1'b0, 1'b1);

    // in_valid held with changing data while busy
    for (int unsigned i = 0; i < 12; i++) step("ignore", 1'b1, make_vec(1'b1, 1'b0), 1'b1, 1'b1);
    for (int unsigned i = 0; i < 5; i++) step("ignore", 1'b0, '0, 1'b0, 1'b1);

    // Asynchronous reset in the middle of a frame
    step("midrst", 1'b1, v_order, 1'b0, 1'b1);
    step("midrst", 1'b0, '0, 1'b0, 1'b1);
    step("midrst", 1'b0, '0, 1'b0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst.out_valid", 64'(out_valid), 64'(0));
    check("midrst.busy",      64'(busy),      64'(0));
    check("midrst.in_ready",  64'(in_ready),  64'(1));
    check("midrst.out_last",  64'(out_last),  64'(0));
    check("midrst.order_err", 64'(order_err), 64'(0));
    q.delete();
    m_err = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step("after_rst", 1'b1, v_after, 1'b1, 1'b1);
    for (int unsigned i = 0; i < 5; i++) step("after_rst", 1'b0, '0, 1'b0, 1'b1);

    // Randomized traffic: mostly sorted vectors, some unsorted, random stalls
    for (int unsigned t = 0; t < 400; t++) begin
      logic dr;
      dr = 1'($urandom_range(0, 1));
      step("rand", 1'($urandom_range(0, 1)), make_vec(dr, $urandom_range(0, 3) != 0),
           dr, $urandom_range(0, 3) != 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int unsigned i = 0; i < 8; i++) step("drain", 1'b0, '0, 1'b0, 1'b1);

    // N = 1 instance: a single word that is also the last one
    one_in_data  = 8'h3C;
    one_in_valid = 1'b1;
    one_out_ready = 1'b0;
    @(posedge clk);
    @(negedge clk);
    one_in_valid = 1'b0;
    one_in_data  = 8'h77;
    for (int unsigned i = 0; i < 2; i++) begin
      check("n1.out_valid", 64'(one_out_valid), 64'(1));
      check("n1.out_data",  64'(one_out_data),  64'(8'h3C));
      check("n1.out_last",  64'(one_out_last),  64'(1));
      check("n1.out_idx",   64'(one_out_idx),   64'(0));
      check("n1.in_ready",  64'(one_in_ready),  64'(0));
      check("n1.busy",      64'(one_busy),      64'(1));
      @(posedge clk);
      @(negedge clk);
    end
    one_out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("n1.idle_in_ready",  64'(one_in_ready),  64'(1));
    check("n1.idle_out_valid", 64'(one_out_valid), 64'(0));
    check("n1.idle_busy",      64'(one_busy),      64'(0));
    check("n1.order_err",      64'(one_order_err), 64'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
